// File: rtl/usb_fs_bit_recovery.sv
// USB full-speed bit recovery: a DPLL re-phased on every line transition gives a mid-bit
// strobe with the sampled line state, plus SE0 and optional bus-reset detection (USB_BUS_RESET_DET_EN).
module usb_fs_bit_recovery #(
    parameter int OVERSAMPLE       = 4,
    parameter int IDLE_BITS        = 8,
    parameter int RESET_SE0_CYCLES = 120
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       dp_sync,
    input  logic       dn_sync,
    input  logic       edge_i,
    output logic       bit_strobe,
    output logic [1:0] line_state,
    output logic       se0,
    output logic       lock,
    output logic       bus_reset
);

    localparam int PW         = $clog2(OVERSAMPLE);
    localparam int IDLE_LIMIT = IDLE_BITS * OVERSAMPLE - 1;
    localparam int IW         = $clog2(IDLE_LIMIT + 1);

    localparam logic [PW-1:0] SAMPLE_PHASE = PW'(OVERSAMPLE / 2);
    localparam logic [IW-1:0] IDLE_MAX     = IW'(IDLE_LIMIT);

    // An EOP (two bit times of SE0) must never be mistaken for a bus reset.
    if (OVERSAMPLE < 4 || (OVERSAMPLE & (OVERSAMPLE - 1)) != 0) begin : g_bad_oversample
        $error("OVERSAMPLE must be a power of two >= 4");
    end
    if (IDLE_BITS < 8) begin : g_bad_idle_bits
        $error("IDLE_BITS must exceed the bit-stuffing run length of 7");
    end
    if (RESET_SE0_CYCLES <= 2 * OVERSAMPLE) begin : g_bad_reset_cycles
        $error("RESET_SE0_CYCLES must be longer than an EOP");
    end

    logic [PW-1:0] phase_q, phase_d;
    logic [IW-1:0] idle_q, idle_d;
    logic          lock_q, lock_d;
    logic          strobe_q, strobe_d;
    logic [1:0]    line_q, line_d;
    logic          se0_q, se0_d;
    logic          timeout;
    logic          sample;

    // The edge cycle counts as phase 0; a timeout coinciding with an edge loses to the edge.
    always_comb begin
        phase_d  = edge_i ? PW'(1) : phase_q + PW'(1);
        idle_d   = edge_i ? '0 : ((idle_q == IDLE_MAX) ? idle_q : idle_q + IW'(1));
        timeout  = !edge_i && (idle_d == IDLE_MAX);
        lock_d   = edge_i ? 1'b1 : (timeout ? 1'b0 : lock_q);
        sample   = lock_q && !timeout && (phase_q == SAMPLE_PHASE);
        strobe_d = sample;
        line_d   = sample ? {dp_sync, dn_sync} : line_q;
        se0_d    = ~dp_sync & ~dn_sync;
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            phase_q  <= '0;
            idle_q   <= '0;
            lock_q   <= 1'b0;
            strobe_q <= 1'b0;
            line_q   <= 2'b00;
            se0_q    <= 1'b0;
        end else begin
            phase_q  <= phase_d;
            idle_q   <= idle_d;
            lock_q   <= lock_d;
            strobe_q <= strobe_d;
            line_q   <= line_d;
            se0_q    <= se0_d;
        end
    end

`ifdef USB_BUS_RESET_DET_EN
    localparam int SW = $clog2(RESET_SE0_CYCLES + 1);
    localparam logic [SW-1:0] SE0_MAX = SW'(RESET_SE0_CYCLES);

    logic [SW-1:0] se0_cnt_q, se0_cnt_d;

    // Counts the current SE0 run; saturating keeps bus_reset high until SE0 ends.
    always_comb begin
        se0_cnt_d = '0;
        if (se0_d) begin
            se0_cnt_d = (se0_cnt_q == SE0_MAX) ? se0_cnt_q : se0_cnt_q + SW'(1);
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            se0_cnt_q <= '0;
        end else begin
            se0_cnt_q <= se0_cnt_d;
        end
    end

    assign bus_reset = (se0_cnt_q == SE0_MAX);
`else
    assign bus_reset = 1'b0;
`endif

    assign bit_strobe = strobe_q;
    assign line_state = line_q;
    assign se0        = se0_q;
    assign lock       = lock_q;

endmodule

// File: tb/tb_usb_fs_bit_recovery.sv
// Self-checking bench for usb_fs_bit_recovery: directed scenarios with constant expectations
// plus a randomized line checked cycle-by-cycle against a timing model built from bit-cell rules.
module tb_usb_fs_bit_recovery;

    localparam int OS      = 4;
    localparam int IDLE    = 8;
    localparam int RST_SE0 = 120;
    localparam int LIM     = IDLE * OS;
    localparam logic [1:0] J   = 2'b10;
    localparam logic [1:0] K   = 2'b01;
    localparam logic [1:0] SE0 = 2'b00;
`ifdef USB_BUS_RESET_DET_EN
    localparam bit BR_EN = 1'b1;
`else
    localparam bit BR_EN = 1'b0;
`endif

    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic       dp_sync = 1'b1;
    logic       dn_sync = 1'b0;
    logic       edge_i = 1'b0;
    logic       bit_strobe;
    logic [1:0] line_state;
    logic       se0;
    logic       lock;
    logic       bus_reset;

    int checks = 0;
    int errors = 0;

    // Input history since the last reset release, indexed by clock cycle.
    logic [1:0] histLvl [0:4095];
    bit         histEdge[0:4095];
    int         n = 0;

    usb_fs_bit_recovery dut (
        .clk        (clk),
        .reset      (reset),
        .dp_sync    (dp_sync),
        .dn_sync    (dn_sync),
        .edge_i     (edge_i),
        .bit_strobe (bit_strobe),
        .line_state (line_state),
        .se0        (se0),
        .lock       (lock),
        .bus_reset  (bus_reset)
    );

    always #5 clk = ~clk;

    initial begin
        #5000000;
        $display("[TB] FAIL watchdog: simulation time limit expired");
        $fatal(1, "[TB] watchdog");
    end

    // Called at a falling edge; applies one cycle of line input and returns at the next falling edge.
    task automatic drive(input logic [1:0] lvl, input bit e);
        dp_sync = lvl[1];
        dn_sync = lvl[0];
        edge_i  = e;
        histLvl[n]  = lvl;
        histEdge[n] = e;
        n++;
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic do_reset();
        reset   = 1'b1;
        dp_sync = 1'b1;
        dn_sync = 1'b0;
        edge_i  = 1'b0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        reset = 1'b0;
        n = 0;
    endtask

    function automatic int lastEdge(input int upto);
        for (int i = upto; i >= 0; i--) begin
            if (histEdge[i]) return i;
        end
        return -1;
    endfunction

    // A cycle samples when it sits half a bit after the last transition (mod one bit),
    // no more than IDLE bit times have passed, and it is not the cycle in which lock times out.
    function automatic bit sampled(input int m);
        int te;
        te = lastEdge(m - 1);
        if (te < 0) return 1'b0;
        if ((m - te) >= LIM) return 1'b0;
        if (!histEdge[m] && (m - te) == LIM - 1) return 1'b0;
        return ((m - te) % OS) == (OS / 2);
    endfunction

    // Expected {bit_strobe, line_state, se0, lock, bus_reset} after cnt clocks since reset.
    function automatic logic [5:0] model(input int cnt);
        logic [1:0] ls;
        int te;
        int run;
        bit br;
        ls = 2'b00;
        if (cnt == 0) return 6'b0;
        for (int m = cnt - 1; m >= 0; m--) begin
            if (sampled(m)) begin
                ls = histLvl[m];
                break;
            end
        end
        te = lastEdge(cnt - 1);
        run = 0;
        for (int i = cnt - 1; i >= 0 && run < RST_SE0; i--) begin
            if (histLvl[i] != SE0) break;
            run++;
        end
        br = BR_EN && (run >= RST_SE0);
        return {sampled(cnt - 1), ls, histLvl[cnt - 1] == SE0, (te >= 0) && (cnt - te < LIM), br};
    endfunction

    task automatic test_reset();
        logic [1:0] lvl;
        $display("[TB] test_reset");
        do_reset();
        checks++;
        if ({bit_strobe, line_state, se0, lock, bus_reset} !== 6'b0) begin
            errors++;
            $display("[TB] FAIL reset_release: got %b expected 000000",
                     {bit_strobe, line_state, se0, lock, bus_reset});
        end
        lvl = K;
        for (int c = 0; c < 5; c++) begin
            for (int k = 0; k < OS; k++) drive(lvl, k == 0);
            lvl = (lvl == K) ? J : K;
        end
        drive(SE0, 1'b1);
        drive(SE0, 1'b0);
        drive(SE0, 1'b0);
        checks++;
        if (lock !== 1'b1 || se0 !== 1'b1 || bit_strobe !== 1'b1) begin
            errors++;
            $display("[TB] FAIL reset_prestate: lock/se0/strobe got %b%b%b expected 111", lock, se0, bit_strobe);
        end
        #2 reset = 1'b1;
        #1;
        checks++;
        if ({bit_strobe, line_state, se0, lock, bus_reset} !== 6'b0) begin
            errors++;
            $display("[TB] FAIL reset_async: got %b expected 000000",
                     {bit_strobe, line_state, se0, lock, bus_reset});
        end
        @(posedge clk);
        @(negedge clk);
        reset = 1'b0;
        n = 0;
        for (int q = 0; q < 10; q++) begin
            drive(J, 1'b0);
            checks++;
            if (bit_strobe !== 1'b0 || lock !== 1'b0) begin
                errors++;
                $display("[TB] FAIL reset_quiet cycle %0d: strobe/lock got %b%b expected 00", q, bit_strobe, lock);
            end
        end
        for (int k = 0; k < OS; k++) begin
            drive(K, k == 0);
            checks++;
            if (bit_strobe !== (k == 2)) begin
                errors++;
                $display("[TB] FAIL reset_first_edge k %0d: strobe got %b expected %b", k, bit_strobe, k == 2);
            end
        end
        checks++;
        if (line_state !== K) begin
            errors++;
            $display("[TB] FAIL reset_first_sample: line_state got %b expected %b", line_state, K);
        end
    endtask

    task automatic test_sync();
        logic [1:0] lvl;
        $display("[TB] test_sync");
        do_reset();
        lvl = K;
        for (int c = 0; c < 8; c++) begin
            for (int k = 0; k < OS; k++) begin
                drive(lvl, k == 0);
                checks++;
                if (bit_strobe !== (k == 2) || lock !== 1'b1) begin
                    errors++;
                    $display("[TB] FAIL sync cell %0d k %0d: strobe/lock got %b%b expected %b1",
                             c, k, bit_strobe, lock, k == 2);
                end
                if (k == 2) begin
                    checks++;
                    if (line_state !== lvl) begin
                        errors++;
                        $display("[TB] FAIL sync_level cell %0d: line_state got %b expected %b", c, line_state, lvl);
                    end
                end
            end
            lvl = (lvl == K) ? J : K;
        end
    endtask

    task automatic test_drift();
        logic [1:0] lvl;
        int len;
        int strobes;
        $display("[TB] test_drift");
        do_reset();
        lvl = K;
        for (int c = 0; c < 10; c++) begin
            len = (c % 2 == 0) ? 5 : 3;
            strobes = 0;
            for (int k = 0; k < len; k++) begin
                drive(lvl, k == 0);
                if (bit_strobe === 1'b1) strobes++;
                checks++;
                if (bit_strobe !== (k == 2)) begin
                    errors++;
                    $display("[TB] FAIL drift cell %0d len %0d k %0d: strobe got %b expected %b",
                             c, len, k, bit_strobe, k == 2);
                end
            end
            checks++;
            if (strobes != 1) begin
                errors++;
                $display("[TB] FAIL drift_count cell %0d: strobes got %0d expected 1", c, strobes);
            end
            lvl = (lvl == K) ? J : K;
        end
    endtask

    task automatic test_idle();
        $display("[TB] test_idle");
        do_reset();
        drive(K, 1'b1);
        for (int q = 1; q <= 31; q++) begin
            drive(K, 1'b0);
            checks++;
            if (lock !== (q < 31) || bit_strobe !== (q % 4 == 2)) begin
                errors++;
                $display("[TB] FAIL idle_drop quiet %0d: lock/strobe got %b%b expected %b%b",
                         q, lock, bit_strobe, q < 31, q % 4 == 2);
            end
        end
        for (int q = 0; q < 8; q++) begin
            drive(K, 1'b0);
            checks++;
            if (lock !== 1'b0 || bit_strobe !== 1'b0) begin
                errors++;
                $display("[TB] FAIL idle_unlocked %0d: lock/strobe got %b%b expected 00", q, lock, bit_strobe);
            end
        end
        do_reset();
        drive(K, 1'b1);
        for (int q = 1; q <= 30; q++) drive(K, 1'b0);
        drive(J, 1'b1);
        checks++;
        if (lock !== 1'b1) begin
            errors++;
            $display("[TB] FAIL idle_edge_wins: lock got %b expected 1", lock);
        end
        for (int q = 32; q <= 35; q++) begin
            drive(J, 1'b0);
            checks++;
            if (lock !== 1'b1 || bit_strobe !== (q == 33)) begin
                errors++;
                $display("[TB] FAIL idle_rephase cycle %0d: lock/strobe got %b%b expected 1%b",
                         q, lock, bit_strobe, q == 33);
            end
        end
        checks++;
        if (line_state !== J) begin
            errors++;
            $display("[TB] FAIL idle_rephase_level: line_state got %b expected %b", line_state, J);
        end
    endtask

    task automatic test_eop();
        logic [1:0] lv[8] = '{K, J, K, J, SE0, SE0, J, J};
        bit         ed[8] = '{1, 1, 1, 1, 1, 0, 1, 0};
        $display("[TB] test_eop");
        do_reset();
        for (int c = 0; c < 8; c++) begin
            for (int k = 0; k < OS; k++) begin
                drive(lv[c], ed[c] && k == 0);
                checks++;
                if (bus_reset !== 1'b0) begin
                    errors++;
                    $display("[TB] FAIL eop_bus_reset cell %0d k %0d: got %b expected 0", c, k, bus_reset);
                end
                if (k == 2) begin
                    checks++;
                    if (bit_strobe !== 1'b1 || line_state !== lv[c]) begin
                        errors++;
                        $display("[TB] FAIL eop_sample cell %0d: strobe/line got %b %b expected 1 %b",
                                 c, bit_strobe, line_state, lv[c]);
                    end
                end
            end
        end
    endtask

    task automatic test_bus_reset();
        bit expBr;
        $display("[TB] test_bus_reset");
        do_reset();
        for (int k = 0; k < OS; k++) drive(J, k == 0);
        for (int i = 1; i <= 200; i++) begin
            drive(SE0, i == 1);
            expBr = BR_EN && (i >= RST_SE0);
            checks++;
            if (bus_reset !== expBr || se0 !== 1'b1) begin
                errors++;
                $display("[TB] FAIL bus_reset se0 cycle %0d: bus_reset/se0 got %b%b expected %b1",
                         i, bus_reset, se0, expBr);
            end
        end
        for (int k = 0; k < OS; k++) begin
            drive(J, k == 0);
            checks++;
            if (bus_reset !== 1'b0 || se0 !== 1'b0) begin
                errors++;
                $display("[TB] FAIL bus_reset_release k %0d: bus_reset/se0 got %b%b expected 00", k, bus_reset, se0);
            end
        end
    endtask

    task automatic test_random();
        logic [1:0] cur;
        logic [1:0] nxt;
        logic [5:0] exp;
        logic [5:0] got;
        int len;
        int kind;
        $display("[TB] test_random");
        do_reset();
        cur = J;
        for (int c = 0; c < 300; c++) begin
            if (n > 3800) begin
                do_reset();
                cur = J;
            end
            kind = $urandom_range(0, 99);
            if (kind < 6) begin
                nxt = SE0;
                len = 2 * OS;
            end else if (kind < 11) begin
                nxt = cur;
                len = $urandom_range(20, 45);
            end else begin
                nxt = ($urandom_range(0, 1) == 1) ? J : K;
                len = $urandom_range(OS - 1, OS + 1);
            end
            for (int k = 0; k < len; k++) begin
                drive(nxt, (k == 0) && (nxt != cur));
                exp = model(n);
                got = {bit_strobe, line_state, se0, lock, bus_reset};
                checks++;
                if (got !== exp) begin
                    errors++;
                    $display("[TB] FAIL random cycle %0d: {strobe,line,se0,lock,bus_reset} got %b expected %b",
                             n, got, exp);
                end
            end
            cur = nxt;
        end
    endtask

    initial begin
        @(negedge clk);
        test_reset();
        test_sync();
        test_drift();
        test_idle();
        test_eop();
        test_bus_reset();
        test_random();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
